hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage MIPS core. Drives the write enables and flushes of the IF/ID and ID/EX enable-gated pipeline registers, selects forwarding paths for EX and the decode-stage branch comparator, and sequences the multi-cycle multiply/divide unit (MDU). It sits beside the datapath and owns every stall, bubble and HI/LO write decision.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mdu_seq.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control slice:
// forwarding select codes, MDU sequencer states and register-index helpers.
package mips_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // $zero is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer: start pulse, MD_LAT busy cycles, then a single
// HI/LO write cycle before returning to IDLE.
module mdu_seq
    import mips_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_e,
    output logic mdu_start,
    output logic md_busy,
    output logic hilo_we,
    output logic idle
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          hilo_we_q, hilo_we_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (md_e) begin
                state_d = BUSY;
                cnt_d   = CW'(MD_LAT - 1);
            end
            BUSY: if (cnt_q == '0) state_d = DONE;
                  else             cnt_d   = cnt_q - CW'(1);
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered alongside the state they describe.
        busy_d    = (state_d != IDLE);
        hilo_we_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hilo_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hilo_we_q <= hilo_we_d;
        end
    end

    assign idle      = (state_q == IDLE);
    assign mdu_start = md_e & idle & ~rst;
    assign md_busy   = busy_q;
    assign hilo_we   = hilo_we_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage pipeline, plus the
// MDU sequencer that owns HI/LO write timing.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             branch_d,
    input  logic             branch_taken_d,
    input  logic             md_d,
    input  logic             mfhilo_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic             memread_e,
    input  logic             regwrite_e,
    input  logic             md_e,
    input  logic [REG_W-1:0] wa_e,
    input  logic [REG_W-1:0] wa_m,
    input  logic [REG_W-1:0] wa_w,
    input  logic             regwrite_m,
    input  logic             memtoreg_m,
    input  logic             regwrite_w,
    output logic             en_f,
    output logic             en_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             mdu_start,
    output logic             md_busy,
    output logic             hilo_we
);

    logic mdu_idle;
    logic lu, bh, mh, stall;

    mdu_seq #(.MD_LAT(MD_LAT)) u_mdu_seq (
        .clk       (clk),
        .rst       (rst),
        .md_e      (md_e),
        .mdu_start (mdu_start),
        .md_busy   (md_busy),
        .hilo_we   (hilo_we),
        .idle      (mdu_idle)
    );

    function automatic logic [1:0] fwd_e_sel(input logic [REG_W-1:0] src);
        if (regwrite_m && reg_hit(wa_m, src))      return FWD_M;
        else if (regwrite_w && reg_hit(wa_w, src)) return FWD_W;
        else                                       return FWD_RF;
    endfunction

    always_comb begin
        lu = memread_e & (reg_hit(rt_e, rs_d) | reg_hit(rt_e, rt_d));
        // The decode-stage comparator can't see E results or M load data.
        bh = branch_d & ((regwrite_e & (reg_hit(wa_e, rs_d) | reg_hit(wa_e, rt_d))) |
                         (memtoreg_m & (reg_hit(wa_m, rs_d) | reg_hit(wa_m, rt_d))));
        // md_e counts as busy: the sequencer only leaves IDLE next cycle.
        mh = (md_d | mfhilo_d) & (~mdu_idle | md_e);
        stall = lu | bh | mh;
    end

    assign en_f    = ~stall;
    assign en_d    = ~stall;
    assign flush_e = stall;
    assign flush_d = branch_taken_d & ~stall;

    assign fwd_a_e = fwd_e_sel(rs_e);
    assign fwd_b_e = fwd_e_sel(rt_e);
    assign fwd_a_d = regwrite_m & reg_hit(wa_m, rs_d);
    assign fwd_b_d = regwrite_m & reg_hit(wa_m, rt_d);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MD_LAT=4) with a queue-based scoreboard.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic       branch_d, branch_taken_d, md_d, mfhilo_d;
    logic       memread_e, regwrite_e, md_e;
    logic       regwrite_m, memtoreg_m, regwrite_w;
    logic       en_f, en_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       mdu_start, md_busy, hilo_we;

    hazard_ctrl #(.MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .branch_taken_d(branch_taken_d),
        .md_d(md_d), .mfhilo_d(mfhilo_d),
        .rs_e(rs_e), .rt_e(rt_e), .memread_e(memread_e), .regwrite_e(regwrite_e), .md_e(md_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .regwrite_w(regwrite_w),
        .en_f(en_f), .en_d(en_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .mdu_start(mdu_start), .md_busy(md_busy), .hilo_we(hilo_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Output vector: {en_f,en_d,flush_d,flush_e,fwd_a_e,fwd_b_e,fwd_a_d,fwd_b_d,start,busy,we}
    function automatic logic [14:0] mk(input bit stall, input bit fd, input logic [1:0] fa,
                                       input logic [1:0] fb, input bit fad, input bit fbd,
                                       input bit st, input bit bz, input bit we);
        return {~stall, ~stall, fd, stall, fa, fb, fad, fbd, st, bz, we};
    endfunction

    task automatic push(input string nm, input logic [14:0] e);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w} = '0;
        {branch_d, branch_taken_d, md_d, mfhilo_d} = '0;
        {memread_e, regwrite_e, md_e, regwrite_m, memtoreg_m, regwrite_w} = '0;
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        logic [14:0] act;
        exp_t        x;
        act = {en_f, en_d, flush_d, flush_e, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d,
               mdu_start, md_busy, hilo_we};
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (act !== x.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", x.name, act, x.exp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(md_e && md_busy))
            else begin
                errors++;
                $display("FAIL md_e_outside_idle: md_e=%b md_busy=%b expected md_busy=0", md_e, md_busy);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr_in();
        cyc(); push("reset", mk(0,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); rst = 1'b0;

        // Load-use
        cyc(); memread_e = 1; rt_e = 5; rs_d = 5;
        push("lu_rs", mk(1,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); rs_d = 0;
        push("lu_r0", mk(0,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); rt_d = 5;
        push("lu_rt", mk(1,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); clr_in();

        // EX forwarding
        rs_e = 7; wa_m = 7; wa_w = 7; regwrite_m = 1; regwrite_w = 1;
        push("fwd_m_prio", mk(0,0,2'b10,2'b00,0,0,0,0,0));
        cyc(); regwrite_m = 0;
        push("fwd_w", mk(0,0,2'b01,2'b00,0,0,0,0,0));
        cyc(); regwrite_m = 1; rs_e = 0; wa_m = 0; wa_w = 0;
        push("fwd_r0", mk(0,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); rt_e = 9; wa_w = 9; wa_m = 3;
        push("fwd_b_w", mk(0,0,2'b00,2'b01,0,0,0,0,0));
        cyc(); clr_in();

        // Decode forwarding and branch hazards
        rs_d = 4; rt_d = 6; wa_m = 6; regwrite_m = 1;
        push("fwd_b_d", mk(0,0,2'b00,2'b00,0,1,0,0,0));
        cyc(); clr_in(); branch_d = 1; branch_taken_d = 1; rs_d = 2; rt_d = 3;
        push("br_flush", mk(0,1,2'b00,2'b00,0,0,0,0,0));
        cyc(); regwrite_e = 1; wa_e = 2;
        push("br_haz_e", mk(1,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); regwrite_e = 0; memtoreg_m = 1; regwrite_m = 1; wa_m = 3;
        push("br_haz_m", mk(1,0,2'b00,2'b00,0,1,0,0,0));
        cyc(); branch_d = 0; branch_taken_d = 0;
        push("load_m_nobr", mk(0,0,2'b00,2'b00,0,1,0,0,0));
        cyc(); clr_in(); branch_d = 1; branch_taken_d = 1; regwrite_e = 1;
        push("br_r0", mk(0,1,2'b00,2'b00,0,0,0,0,0));
        cyc(); clr_in();

        // MDU sequence: start at c0, mfhilo_d held from c2
        md_e = 1; md_d = 1;
        push("md_c0", mk(1,0,2'b00,2'b00,0,0,1,0,0));
        cyc(); md_e = 0; md_d = 0;
        push("md_c1", mk(0,0,2'b00,2'b00,0,0,0,1,0));
        for (int c = 2; c <= 4; c++) begin
            cyc(); mfhilo_d = 1;
            push($sformatf("md_c%0d", c), mk(1,0,2'b00,2'b00,0,0,0,1,0));
        end
        cyc(); push("md_c5_done", mk(1,0,2'b00,2'b00,0,0,0,1,1));
        cyc(); push("md_c6_idle", mk(0,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); clr_in();

        // Reset mid-BUSY
        md_e = 1;
        push("rs_c0", mk(0,0,2'b00,2'b00,0,0,1,0,0));
        cyc(); md_e = 0;
        push("rs_c1", mk(0,0,2'b00,2'b00,0,0,0,1,0));
        cyc(); push("rs_c2", mk(0,0,2'b00,2'b00,0,0,0,1,0));
        cyc(); rst = 1; md_e = 1; md_d = 1;
        push("rst_async", mk(1,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); md_e = 0; md_d = 0;
        push("rst_hold", mk(0,0,2'b00,2'b00,0,0,0,0,0));
        cyc(); rst = 0; md_e = 1;
        push("re_c0", mk(0,0,2'b00,2'b00,0,0,1,0,0));
        for (int c = 1; c <= 4; c++) begin
            cyc(); md_e = 0;
            push($sformatf("re_c%0d", c), mk(0,0,2'b00,2'b00,0,0,0,1,0));
        end
        cyc(); push("re_c5_done", mk(0,0,2'b00,2'b00,0,0,0,1,1));
        cyc(); push("re_c6_idle", mk(0,0,2'b00,2'b00,0,0,0,0,0));

        for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
